// File: rtl/axis_packet_monitor.sv
// Purpose: passive AXI4-Stream observer; sticky protocol error flags plus per-TDEST packet beat/byte reports.
// Latency: errors and packet reports are registered, visible the cycle after the offending / tlast beat.
// Backpressure: none; only observes the link. Optional stall timeout: `AXIS_PACKET_MONITOR_STALL_TIMEOUT_EN.
module axis_packet_monitor #(
    parameter int BYTE_WIDTH    = 4,
    parameter int DEST_WIDTH    = 2,
    parameter int MAX_PKT_BEATS = 256,
    parameter int CNT_WIDTH     = 16,
    parameter int STALL_LIMIT   = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    tvalid,
    input  logic                    tready,
    input  logic [8*BYTE_WIDTH-1:0] tdata,
    input  logic [BYTE_WIDTH-1:0]   tstrb,
    input  logic [BYTE_WIDTH-1:0]   tkeep,
    input  logic                    tlast,
    input  logic [DEST_WIDTH-1:0]   tdest,
    input  logic                    err_clear,
    output logic [5:0]              err_flags,
    output logic                    pkt_done,
    output logic [DEST_WIDTH-1:0]   pkt_dest,
    output logic [CNT_WIDTH-1:0]    pkt_beats,
    output logic [CNT_WIDTH-1:0]    pkt_bytes,
    output logic [CNT_WIDTH-1:0]    pkt_total
);
    localparam int                   NUM_DEST  = 2**DEST_WIDTH;
    localparam int                   PW        = 8*BYTE_WIDTH + 2*BYTE_WIDTH + 1 + DEST_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX_BEATS = CNT_WIDTH'(MAX_PKT_BEATS);
    localparam logic [CNT_WIDTH:0]   BYTES_SAT = {1'b0, {CNT_WIDTH{1'b1}}};
    localparam logic                 ST_IDLE   = 1'b0;
    localparam logic                 ST_IN_PKT = 1'b1;

    function automatic logic [CNT_WIDTH:0] popcnt(input logic [BYTE_WIDTH-1:0] v);
        popcnt = '0;
        for (int i = 0; i < BYTE_WIDTH; i++) begin
            popcnt = popcnt + {{CNT_WIDTH{1'b0}}, v[i]};
        end
    endfunction

    logic                               xfer;
    logic [PW-1:0]                      payload;
    logic [CNT_WIDTH:0]                 keep_cnt;
    logic [CNT_WIDTH-1:0]               base_beats, base_bytes, beats_nxt, bytes_nxt;
    logic [CNT_WIDTH:0]                 bytes_sum;
    logic                               stall_det;
    logic [5:0]                         err_det;

    logic [NUM_DEST-1:0]                state_q, state_d;
    logic [NUM_DEST-1:0][CNT_WIDTH-1:0] beats_q, beats_d;
    logic [NUM_DEST-1:0][CNT_WIDTH-1:0] bytes_q, bytes_d;
    logic                               past_ok_q, past_ok_d;
    logic                               prv_valid_q, prv_valid_d;
    logic                               prv_ready_q, prv_ready_d;
    logic [PW-1:0]                      prv_payload_q, prv_payload_d;
    logic [5:0]                         err_q, err_d;
    logic                               pkt_done_q, pkt_done_d;
    logic [DEST_WIDTH-1:0]              pkt_dest_q, pkt_dest_d;
    logic [CNT_WIDTH-1:0]               pkt_beats_q, pkt_beats_d;
    logic [CNT_WIDTH-1:0]               pkt_bytes_q, pkt_bytes_d;
    logic [CNT_WIDTH-1:0]               pkt_total_q, pkt_total_d;

    assign xfer     = tvalid && tready;
    assign payload  = {tdata, tstrb, tkeep, tlast, tdest};
    assign keep_cnt = popcnt(tkeep);

`ifdef AXIS_PACKET_MONITOR_STALL_TIMEOUT_EN
    localparam int            SW        = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    // Count consecutive stalled cycles, holding once the limit is reached.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!tvalid || tready) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_det = past_ok_q && (stall_cnt_d == STALL_MAX);
`else
    logic unused_stall_limit;
    assign unused_stall_limit = ^32'(STALL_LIMIT);
    assign stall_det          = 1'b0;
`endif

    // Per-channel next state: only the channel named by tdest moves.
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d[tdest] = tlast ? ST_IDLE : ST_IN_PKT;
        end
    end

    // Per-channel counters and the registered packet report.
    always_comb begin
        base_beats  = (state_q[tdest] == ST_IN_PKT) ? beats_q[tdest] : '0;
        base_bytes  = (state_q[tdest] == ST_IN_PKT) ? bytes_q[tdest] : '0;
        beats_nxt   = (base_beats >= MAX_BEATS) ? MAX_BEATS : base_beats + CNT_WIDTH'(1);
        bytes_sum   = {1'b0, base_bytes} + keep_cnt;
        bytes_nxt   = (bytes_sum > BYTES_SAT) ? BYTES_SAT[CNT_WIDTH-1:0] : bytes_sum[CNT_WIDTH-1:0];
        beats_d     = beats_q;
        bytes_d     = bytes_q;
        pkt_done_d  = 1'b0;
        pkt_dest_d  = pkt_dest_q;
        pkt_beats_d = pkt_beats_q;
        pkt_bytes_d = pkt_bytes_q;
        pkt_total_d = pkt_total_q;
        if (xfer) begin
            if (tlast) begin
                beats_d[tdest] = '0;
                bytes_d[tdest] = '0;
                pkt_done_d     = 1'b1;
                pkt_dest_d     = tdest;
                pkt_beats_d    = beats_nxt;
                pkt_bytes_d    = bytes_nxt;
                pkt_total_d    = pkt_total_q + CNT_WIDTH'(1);
            end else begin
                beats_d[tdest] = beats_nxt;
                bytes_d[tdest] = bytes_nxt;
            end
        end
    end

    // Protocol checks against last cycle's sample; set wins over a same-cycle clear.
    always_comb begin
        err_det[0]    = past_ok_q && prv_valid_q && !prv_ready_q && !tvalid;
        err_det[1]    = past_ok_q && prv_valid_q && !prv_ready_q && (payload != prv_payload_q);
        err_det[2]    = tvalid && |(tstrb & ~tkeep);
        err_det[3]    = xfer && !tlast && (base_beats >= MAX_BEATS);
        err_det[4]    = xfer && (tkeep == '0) && tlast;
        err_det[5]    = stall_det;
        err_d         = (err_clear ? 6'b0 : err_q) | err_det;
        past_ok_d     = 1'b1;
        prv_valid_d   = tvalid;
        prv_ready_d   = tready;
        prv_payload_d = payload;
    end

    // State register for all monitor flops.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= '0;
            beats_q       <= '0;
            bytes_q       <= '0;
            past_ok_q     <= 1'b0;
            prv_valid_q   <= 1'b0;
            prv_ready_q   <= 1'b0;
            prv_payload_q <= '0;
            err_q         <= '0;
            pkt_done_q    <= 1'b0;
            pkt_dest_q    <= '0;
            pkt_beats_q   <= '0;
            pkt_bytes_q   <= '0;
            pkt_total_q   <= '0;
        end else begin
            state_q       <= state_d;
            beats_q       <= beats_d;
            bytes_q       <= bytes_d;
            past_ok_q     <= past_ok_d;
            prv_valid_q   <= prv_valid_d;
            prv_ready_q   <= prv_ready_d;
            prv_payload_q <= prv_payload_d;
            err_q         <= err_d;
            pkt_done_q    <= pkt_done_d;
            pkt_dest_q    <= pkt_dest_d;
            pkt_beats_q   <= pkt_beats_d;
            pkt_bytes_q   <= pkt_bytes_d;
            pkt_total_q   <= pkt_total_d;
        end
    end

    assign err_flags = err_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_dest  = pkt_dest_q;
    assign pkt_beats = pkt_beats_q;
    assign pkt_bytes = pkt_bytes_q;
    assign pkt_total = pkt_total_q;
endmodule

// File: doc/axis_packet_monitor.md
Name: axis_packet_monitor

Overview:
- Synthesizable, in-line, passive AXI4-Stream observer. Taps a master->slave link and drives no stream signals.
- Checks handshake and payload-stability rules at runtime. Sticky errors go to a status block.
- Tracks packets per TDEST channel. Reports beat and byte counts when each packet completes.
- Sits beside stream FIFOs and switches for silicon/FPGA debug, where formal property sets cannot run.

Parameters:
- BYTE_WIDTH, 4, TDATA bytes; must be >= 1.
- DEST_WIDTH, 2, TDEST bits; must be >= 1. Channels tracked: NUM_DEST = 2**DEST_WIDTH.
- MAX_PKT_BEATS, 256, legal packet length limit in beats; must be >= 1.
- CNT_WIDTH, 16, width of beat and byte counters.
- STALL_LIMIT, 1024, cycles tvalid&&!tready may persist; used only with the optional feature.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- tvalid  in  1  observed TVALID
- tready  in  1  observed TREADY
- tdata  in  8*BYTE_WIDTH  observed TDATA
- tstrb  in  BYTE_WIDTH  observed TSTRB
- tkeep  in  BYTE_WIDTH  observed TKEEP
- tlast  in  1  observed TLAST
- tdest  in  DEST_WIDTH  observed TDEST
- err_clear  in  1  single-cycle pulse; clears err_flags
- err_flags  out  6  sticky error bits (see Behaviour)
- pkt_done  out  1  one-cycle pulse per completed packet
- pkt_dest  out  DEST_WIDTH  TDEST of completed packet
- pkt_beats  out  CNT_WIDTH  beats in completed packet
- pkt_bytes  out  CNT_WIDTH  bytes in completed packet (sum of popcount(tkeep))
- pkt_total  out  CNT_WIDTH  packets completed since reset; wraps modulo 2**CNT_WIDTH

Behaviour:
- Reset (aresetn low, async): all outputs 0. Per-channel counters 0. Per-channel state IDLE. Internal past-sample registers 0. past_ok = 0.
- past_ok: set 1 on the first aclk edge with aresetn high. Checks 0, 1 and 5 are gated by past_ok.
- Handshake: xfer = tvalid && tready.
- Previous-cycle values: prv_valid, prv_ready, prv_payload = {tdata, tstrb, tkeep, tlast, tdest}, registered every cycle.
- Error bits (set on the aclk edge after the violating cycle is sampled):
  - bit0 DROP: past_ok && prv_valid && !prv_ready && !tvalid.
  - bit1 UNSTABLE: past_ok && prv_valid && !prv_ready && payload != prv_payload.
  - bit2 STRB_NO_KEEP: tvalid && |(tstrb & ~tkeep).
  - bit3 OVERLONG: xfer && !tlast while the channel's beat count is already MAX_PKT_BEATS.
  - bit4 NULL_BEAT: xfer && tkeep == 0 && tlast. Null beats with tlast=0 are legal.
  - bit5 STALL: see Optional Feature. Tied 0 without it.
- Sticky clear: err_clear clears all bits. If a new error is detected in the same cycle, the new error's bit is set (set wins); other bits clear.
- Per-channel FSM, indexed by tdest, with states IDLE and IN_PKT:
  - IDLE, xfer && !tlast -> IN_PKT. beats = 1, bytes = popcount(tkeep).
  - IDLE, xfer && tlast -> stay IDLE. Report a single-beat packet.
  - IN_PKT, xfer && !tlast -> stay IN_PKT. beats += 1, saturating at MAX_PKT_BEATS. bytes += popcount, saturating at 2**CNT_WIDTH-1.
  - IN_PKT, xfer && tlast -> IDLE. Report beats+1 (saturated) and bytes+popcount (saturated). Counters clear.
  - Interleaving across different tdest values is legal; each channel is independent. Only the channel named by tdest updates in a given cycle.
- Report timing: pkt_done, pkt_dest, pkt_beats and pkt_bytes are registered and valid in the cycle after the tlast handshake.
  - pkt_dest, pkt_beats and pkt_bytes hold their value until the next report.
  - pkt_total increments in the same cycle pkt_done is high.
- Back-to-back tlast beats: produce back-to-back pkt_done pulses. None are lost.
- Reset mid-packet: channel state and counts are discarded. No report is issued.
- Scope: the monitor never affects tvalid or tready, and has no combinational path from stream inputs to outputs.

Optional Feature:
- Macro: AXIS_PACKET_MONITOR_STALL_TIMEOUT_EN.
- Defined:
  - stall_cnt (width $clog2(STALL_LIMIT+1)) increments each cycle tvalid && !tready.
  - Clears on xfer or !tvalid.
  - When stall_cnt reaches STALL_LIMIT, err_flags[5] sets and stall_cnt holds.
- Undefined: no counter logic; err_flags[5] is constant 0.

Test Plan:
- Reset release, then a 4-beat packet on tdest=2 with tkeep=4'hF and tlast on beat 4 -> next cycle: pkt_done=1, pkt_dest=2, pkt_beats=4, pkt_bytes=16, pkt_total=1; err_flags=0.
- Interleave tdest=0 (3 beats, last tkeep=4'h3) with tdest=1 (2 beats) -> two pulses: dest1 beats=2 bytes=8, then dest0 beats=3 bytes=10; pkt_total=2.
- tvalid=1, tready=0, tdata changes 0xA5A5A5A5 -> 0x5A5A5A5A next cycle -> err_flags[1]=1. Then drop tvalid while still stalled -> err_flags[0]=1. Pulse err_clear -> err_flags=0.
- tvalid with tstrb=4'b0011, tkeep=4'b0001 -> err_flags[2]=1. With MAX_PKT_BEATS=4, send 5 beats with no tlast -> err_flags[3]=1. Send the 6th beat with tlast -> pkt_beats=4 (saturated).
- err_clear pulsed in the same cycle as a new NULL_BEAT (tkeep=0, tlast=1) -> err_flags=6'b010000.
- Macro defined, STALL_LIMIT=8: tvalid=1, tready=0 for 8 cycles -> err_flags[5]=1. Macro undefined, same stimulus -> err_flags[5]=0.
